ama_riscv_mem_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (imem) and the load/store requester (dmem) of the pipeline.
- Arbitrates requests with dmem priority plus a starvation guard for fetch.
- Holds a grant stable until it is accepted.
- Tracks outstanding reads in an in-order tag FIFO and routes each memory response back to its originator.

---
 rtl/ama_riscv_mem_arbiter_if.sv | 31 +++
 rtl/ama_riscv_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ama_riscv_mem_arbiter_if
// One memory port: a request channel and an in-order read response channel.
//   master : the side that issues requests and consumes responses
//            (drives req_*, rsp_ready; receives req_ready, rsp_valid, rsp_data)
//   slave  : the side that accepts requests and returns responses
// req_we is a byte write mask; 0 means the request is a read.
// ---------------------------------------------------------------------------
interface ama_riscv_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_we;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ama_riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ama_riscv_mem_arbiter
// Shares one memory port between instruction fetch (imem) and load/store
// (dmem). dmem has priority; imem is forced through after STARVE_LIM lost
// arbitrations. A stalled grant is locked until accepted. Outstanding reads
// are tracked in an in-order tag FIFO that steers each response back.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   imem       : fetch requester (slave modport, write fields ignored)
//   dmem       : load/store requester (slave modport)
//   mem        : unified memory port (master modport)
//   outst_cnt  : reads in flight
//   proto_err  : sticky protocol error (locked requester dropped valid,
//                or a response arrived with nothing outstanding)
// ---------------------------------------------------------------------------
module ama_riscv_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 4,
    localparam int CW        = $clog2(MAX_OUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    ama_riscv_mem_arbiter_if.slave  imem,
    ama_riscv_mem_arbiter_if.slave  dmem,
    ama_riscv_mem_arbiter_if.master mem,
    output logic [CW-1:0]          outst_cnt,
    output logic                   proto_err
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [PW-1:0] LAST_IDX   = PW'(MAX_OUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {GNT_NONE, GNT_IMEM, GNT_DMEM} gnt_e;
    typedef enum logic [1:0] {LK_IDLE, LK_IMEM, LK_DMEM} lock_e;

    lock_e              state_q, state_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic [MAX_OUT-1:0] tag_q, tag_d;
    logic [PW-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic               wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               proto_err_q, proto_err_d;

    gnt_e gnt;
    logic full, empty;
    logic d_is_rd, i_elig, d_elig, lock_drop;
    logic mem_hs, push, pop, head_tag, rsp_live;

    // Fetch port never writes; its write fields are intentionally sunk.
    logic unused_imem_wr;
    assign unused_imem_wr = ^{imem.req_wdata, imem.req_we};

    // Extra wrap bit separates full from empty when the indices match.
    assign full  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
    assign empty = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);

    // ---------------- grant / lock FSM ----------------
    always_comb begin
        state_d   = state_q;
        gnt       = GNT_NONE;
        lock_drop = 1'b0;
        d_is_rd   = (dmem.req_we == 4'b0);
        // Reads need a free tag slot; the FIFO state is registered, so a
        // same-cycle pop does not free a slot for this cycle's push.
        i_elig    = imem.req_valid && !full;
        d_elig    = dmem.req_valid && (!d_is_rd || !full);

        unique case (state_q)
            LK_IMEM: if (imem.req_valid) gnt = GNT_IMEM; else lock_drop = 1'b1;
            LK_DMEM: if (dmem.req_valid) gnt = GNT_DMEM; else lock_drop = 1'b1;
            default: ;
        endcase

        // A dropped lock falls back to normal arbitration in the same cycle.
        if (state_q == LK_IDLE || lock_drop) begin
            if (i_elig && (starve_q == STARVE_MAX || !d_elig)) gnt = GNT_IMEM;
            else if (d_elig)                                     gnt = GNT_DMEM;
        end

        if (rst) gnt = GNT_NONE;

        // Stalled grant is held; a handshake or idle cycle releases it.
        if (gnt != GNT_NONE && !mem.req_ready)
            state_d = (gnt == GNT_IMEM) ? LK_IMEM : LK_DMEM;
        else
            state_d = LK_IDLE;
    end

    // ---------------- request path ----------------
    assign mem.req_valid = (gnt != GNT_NONE);
    assign mem.req_addr  = (gnt == GNT_DMEM) ? dmem.req_addr :
                           (gnt == GNT_IMEM) ? imem.req_addr : '0;
    assign mem.req_wdata = (gnt == GNT_DMEM) ? dmem.req_wdata : '0;
    assign mem.req_we    = (gnt == GNT_DMEM) ? dmem.req_we    : 4'b0;
    assign imem.req_ready = (gnt == GNT_IMEM) && mem.req_ready;
    assign dmem.req_ready = (gnt == GNT_DMEM) && mem.req_ready;

    assign mem_hs = mem.req_valid && mem.req_ready;
    assign push   = mem_hs && ((gnt == GNT_IMEM) || d_is_rd);

    // ---------------- response path ----------------
    assign head_tag      = tag_q[rd_idx_q];
    assign rsp_live      = mem.rsp_valid && !empty && !rst;
    assign imem.rsp_valid = rsp_live && !head_tag;
    assign dmem.rsp_valid = rsp_live &&  head_tag;
    assign mem.rsp_ready  = !empty && !rst &&
                            (head_tag ? dmem.rsp_ready : imem.rsp_ready);
    assign imem.rsp_data  = rst ? '0 : mem.rsp_data;
    assign dmem.rsp_data  = rst ? '0 : mem.rsp_data;
    assign pop            = mem.rsp_valid && mem.rsp_ready;

    // ---------------- bookkeeping ----------------
    always_comb begin
        tag_d       = tag_q;
        wr_idx_d    = wr_idx_q;
        wr_wrap_d   = wr_wrap_q;
        rd_idx_d    = rd_idx_q;
        rd_wrap_d   = rd_wrap_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q | lock_drop | (mem.rsp_valid && empty);

        if (push) begin
            tag_d[wr_idx_q] = (gnt == GNT_DMEM);
            wr_idx_d        = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
            wr_wrap_d       = wr_wrap_q ^ (wr_idx_q == LAST_IDX);
        end
        if (pop) begin
            rd_idx_d  = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
            rd_wrap_d = rd_wrap_q ^ (rd_idx_q == LAST_IDX);
        end

        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        // Counts dmem wins only while fetch is actually waiting.
        if (mem_hs && gnt == GNT_IMEM)
            starve_d = '0;
        else if (mem_hs && gnt == GNT_DMEM && imem.req_valid && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LK_IDLE;
            starve_q    <= '0;
            tag_q       <= '0;
            wr_idx_q    <= '0;
            wr_wrap_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_wrap_q   <= 1'b0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tag_q       <= tag_d;
            wr_idx_q    <= wr_idx_d;
            wr_wrap_q   <= wr_wrap_d;
            rd_idx_q    <= rd_idx_d;
            rd_wrap_q   <= rd_wrap_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outst_cnt = cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
module tb_ama_riscv_mem_arbiter;
    localparam int AW = 32, DW = 32, MAX_OUT = 2, STARVE_LIM = 4;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] outst_cnt;
    logic          proto_err;
    int            checks = 0;
    int            failures = 0;

    ama_riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) imem_bus ();
    ama_riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) dmem_bus ();
    ama_riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

    ama_riscv_mem_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst), .imem(imem_bus), .dmem(dmem_bus), .mem(mem_bus),
        .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {mem_req_valid, imem_req_ready, dmem_req_ready, imem_rsp_valid, dmem_rsp_valid, mem_rsp_ready}
    task automatic chk_st(input string tag, input logic [5:0] exp);
        chk(tag, {mem_bus.req_valid, imem_bus.req_ready, dmem_bus.req_ready,
                  imem_bus.rsp_valid, dmem_bus.rsp_valid, mem_bus.rsp_ready}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        imem_bus.req_valid = 0; imem_bus.req_addr = '0; imem_bus.req_wdata = '0; imem_bus.req_we = '0;
        imem_bus.rsp_ready = 0;
        dmem_bus.req_valid = 0; dmem_bus.req_addr = '0; dmem_bus.req_wdata = '0; dmem_bus.req_we = '0;
        dmem_bus.rsp_ready = 0;
        mem_bus.req_ready = 0; mem_bus.rsp_valid = 0; mem_bus.rsp_data = '0;
    endtask

    task automatic rd_imem(input logic [31:0] a);
        imem_bus.req_valid = 1; imem_bus.req_addr = a;
    endtask

    task automatic req_dmem(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        dmem_bus.req_valid = 1; dmem_bus.req_addr = a; dmem_bus.req_we = we; dmem_bus.req_wdata = wd;
    endtask

    task automatic rsp(input logic [31:0] d);
        mem_bus.rsp_valid = 1; mem_bus.rsp_data = d;
        imem_bus.rsp_ready = 1; dmem_bus.rsp_ready = 1;
    endtask

    // random-phase reference state
    bit   pend[$];          // tags of reads in flight, oldest first (1 = dmem)
    int   lock_who;         // 0 none, 1 imem, 2 dmem
    int   starve;
    bit   iv, dv, mready, rv, irr, drr;
    logic [31:0] ia, da, dwd, rdata;
    logic [3:0]  dwe;
    bit   starve_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        // ---------------- reset masks every handshake output ----------------
        idle_all();
        rst = 1;
        rd_imem(32'h10); req_dmem(32'h20, 4'h0, 0); rsp(32'h55); mem_bus.req_ready = 1;
        #1;
        chk_st("rst_valids", 6'b000000);
        chk("rst_data", {imem_bus.rsp_data, dmem_bus.rsp_data, mem_bus.req_addr}, '0);
        tick();
        rst = 0; idle_all();
        #1;
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_err", proto_err, 0);

        // ---------------- single fetch ----------------
        rd_imem(32'h100); mem_bus.req_ready = 1;
        #1;
        chk_st("fetch_gnt", 6'b110000);
        chk("fetch_addr", {mem_bus.req_addr, mem_bus.req_we}, {32'h100, 4'h0});
        tick();
        idle_all();
        #1; chk("fetch_cnt1", outst_cnt, 1);
        tick();
        rsp(32'hDEADBEEF);
        #1;
        chk_st("fetch_rsp", 6'b000101);
        chk("fetch_data", imem_bus.rsp_data, 32'hDEADBEEF);
        tick();
        idle_all();
        #1; chk("fetch_cnt0", outst_cnt, 0);

        // ---------------- collision: dmem first ----------------
        rd_imem(32'h104); req_dmem(32'h200, 4'h0, 0); mem_bus.req_ready = 1;
        #1;
        chk_st("coll_d", 6'b101000);
        chk("coll_d_addr", mem_bus.req_addr, 32'h200);
        tick();
        dmem_bus.req_valid = 0;
        #1;
        chk_st("coll_i", 6'b110000);
        chk("coll_i_addr", mem_bus.req_addr, 32'h104);
        tick();
        idle_all();
        #1; chk("coll_cnt2", outst_cnt, 2);
        rsp(32'hA);
        #1;
        chk_st("coll_rsp_d", 6'b000011);
        chk("coll_data_d", dmem_bus.rsp_data, 32'hA);
        tick();
        rsp(32'hB);
        #1;
        chk_st("coll_rsp_i", 6'b000101);
        chk("coll_data_i", imem_bus.rsp_data, 32'hB);
        tick();
        idle_all();
        #1; chk("coll_cnt0", outst_cnt, 0);

        // ---------------- starvation: D,D,D,D,I repeating ----------------
        rd_imem(32'h108); req_dmem(32'h208, 4'h0, 0); mem_bus.req_ready = 1;
        imem_bus.rsp_ready = 1; dmem_bus.rsp_ready = 1;
        for (int k = 0; k < 10; k++) begin
            mem_bus.rsp_valid = (k > 0);   // one read always in flight after the first
            mem_bus.rsp_data  = k;
            #1;
            chk($sformatf("starve_gnt%0d", k), {imem_bus.req_ready, dmem_bus.req_ready},
                starve_seq[k] ? 2'b10 : 2'b01);
            tick();
        end
        imem_bus.req_valid = 0; dmem_bus.req_valid = 0; mem_bus.rsp_valid = 1;
        tick();
        idle_all();
        #1; chk("starve_cnt0", outst_cnt, 0);

        // ---------------- lock ----------------
        rd_imem(32'h400);                        // stalled fetch is locked
        tick();
        req_dmem(32'h500, 4'hF, 32'h1);
        #1;
        chk("lock_i_addr", mem_bus.req_addr, 32'h400);
        chk_st("lock_i_hold", 6'b100000);
        mem_bus.req_ready = 1;
        #1; chk_st("lock_i_hs", 6'b110000);
        tick();
        imem_bus.req_addr = 32'h404;
        for (int k = 0; k < 3; k++) begin       // three store wins raise the starve count to 3
            #1; chk($sformatf("lock_st%0d", k), {imem_bus.req_ready, dmem_bus.req_ready}, 2'b01);
            tick();
        end
        req_dmem(32'h300, 4'hF, 32'h12345678); mem_bus.req_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lock_d%0d", k), {mem_bus.req_valid, mem_bus.req_addr, mem_bus.req_we,
                imem_bus.req_ready, dmem_bus.req_ready}, {1'b1, 32'h300, 4'hF, 2'b00});
            tick();
        end
        mem_bus.req_ready = 1;
        #1;
        chk("lock_d_hs", {dmem_bus.req_ready, mem_bus.req_wdata}, {1'b1, 32'h12345678});
        tick();
        req_dmem(32'h304, 4'hF, 32'h2);
        #1;
        chk("lock_starve_i", {imem_bus.req_ready, dmem_bus.req_ready, mem_bus.req_addr}, {2'b10, 32'h404});
        chk("lock_no_tag", outst_cnt, 1);
        tick();
        idle_all();
        #1; chk("lock_cnt2", outst_cnt, 2);

        // ---------------- full FIFO ----------------
        req_dmem(32'h208, 4'h0, 0); mem_bus.req_ready = 1;
        rsp(32'h77);
        #1;
        chk_st("full_blocked", 6'b000101);
        tick();
        mem_bus.rsp_valid = 0;
        #1; chk("full_next", {outst_cnt, dmem_bus.req_ready}, {2'd1, 1'b1});
        tick();
        req_dmem(32'h50C, 4'h3, 32'h9);
        #1; chk("full_store", {outst_cnt, dmem_bus.req_ready}, {2'd2, 1'b1});
        tick();
        dmem_bus.req_valid = 0; rd_imem(32'h408);
        #1; chk("full_imem", mem_bus.req_valid, 0);
        idle_all();
        rsp(32'h88);
        #1; chk_st("drain_i", 6'b000101);
        tick();
        rsp(32'h99);
        #1;
        chk_st("drain_d", 6'b000011);
        chk("drain_d_data", dmem_bus.rsp_data, 32'h99);
        tick();
        idle_all();
        #1; chk("drain_cnt0", outst_cnt, 0);

        // ---------------- response with nothing outstanding ----------------
        rsp(32'h1);
        #1; chk_st("err_drop", 6'b000000);
        tick();
        idle_all();
        #1; chk("err_set", proto_err, 1);
        tick();
        #1; chk("err_sticky", proto_err, 1);

        // ---------------- reset mid-transaction ----------------
        rd_imem(32'h600); mem_bus.req_ready = 1;
        tick();
        imem_bus.req_addr = 32'h604;
        tick();
        imem_bus.req_valid = 0;
        #1; chk("mid_cnt2", outst_cnt, 2);
        rst = 1;
        rd_imem(32'h608); req_dmem(32'h608, 4'h0, 0); rsp(32'h3);
        #1; chk_st("mid_rst_valids", 6'b000000);
        tick();
        rst = 0; idle_all();
        #1;
        chk("mid_cnt0", outst_cnt, 0);
        chk("mid_err0", proto_err, 0);
        chk_st("mid_valids", 6'b000000);

        // ---------------- locked requester drops valid ----------------
        rd_imem(32'h700);
        tick();
        imem_bus.req_valid = 0;
        #1; chk("drop_pre", proto_err, 0);
        tick();
        #1; chk("drop_err", proto_err, 1);
        rst = 1; idle_all();
        tick();
        rst = 0;

        // ---------------- randomized traffic vs reference ----------------
        lock_who = 0; starve = 0;
        iv = 0; dv = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit full, i_el, d_rd, d_el, hs, ne, tgt, mrr, pop;
            int win;
            if (!iv && $urandom_range(0, 2) != 0) begin iv = 1; ia = $urandom; end
            if (!dv && $urandom_range(0, 2) != 0) begin
                dv = 1; da = $urandom; dwd = $urandom;
                dwe = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            mready = ($urandom_range(0, 3) != 0);
            rv     = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
            rdata  = $urandom;
            irr    = ($urandom_range(0, 3) != 0);
            drr    = ($urandom_range(0, 3) != 0);
            imem_bus.req_valid = iv; imem_bus.req_addr = ia;
            dmem_bus.req_valid = dv; dmem_bus.req_addr = da; dmem_bus.req_we = dwe; dmem_bus.req_wdata = dwd;
            mem_bus.req_ready = mready; mem_bus.rsp_valid = rv; mem_bus.rsp_data = rdata;
            imem_bus.rsp_ready = irr; dmem_bus.rsp_ready = drr;
            #1;
            full = (pend.size() == MAX_OUT);
            d_rd = (dwe == 4'h0);
            i_el = iv && !full;
            d_el = dv && (!d_rd || !full);
            if (lock_who != 0)                               win = lock_who;
            else if (i_el && (starve == STARVE_LIM || !d_el)) win = 1;
            else if (d_el)                                   win = 2;
            else                                             win = 0;
            hs  = (win != 0) && mready;
            ne  = (pend.size() > 0);
            tgt = ne ? pend[0] : 1'b0;
            mrr = ne && (tgt ? drr : irr);
            pop = rv && mrr;
            chk("rnd_st", {mem_bus.req_valid, imem_bus.req_ready, dmem_bus.req_ready,
                           imem_bus.rsp_valid, dmem_bus.rsp_valid, mem_bus.rsp_ready},
                {win != 0, hs && win == 1, hs && win == 2, rv && ne && !tgt, rv && ne && tgt, mrr});
            chk("rnd_cnt", outst_cnt, pend.size());
            if (win == 1) chk("rnd_req_i", {mem_bus.req_addr, mem_bus.req_we}, {ia, 4'h0});
            if (win == 2) chk("rnd_req_d", {mem_bus.req_addr, mem_bus.req_we, mem_bus.req_wdata}, {da, dwe, dwd});
            if (rv && ne) chk("rnd_rsp_data", tgt ? dmem_bus.rsp_data : imem_bus.rsp_data, rdata);
            // advance the reference
            lock_who = ((win != 0) && !mready) ? win : 0;
            if (pop) void'(pend.pop_front());
            if (hs && win == 1) begin
                starve = 0; iv = 0; pend.push_back(1'b0);
            end
            if (hs && win == 2) begin
                if (iv && starve < STARVE_LIM) starve++;
                dv = 0;
                if (d_rd) pend.push_back(1'b1);
            end
            tick();
        end
        chk("rnd_err", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
